// File: rtl/rank_filter_pkg.sv
// Shared definitions for the 3x3 rank-order filter.
//  - rank constants and pipeline latency
//  - 9-input sorting network: 25 compare-exchanges in 7 layers, one layer per
//    register stage. Entry [layer][slot] pairs NET_LO with NET_HI. Only the
//    first NET_CNT[layer] slots of a layer are used.
//  - rank clamp and a pairing lookup used to find pass-through elements
package rank_filter_pkg;

  localparam int RANK_MIN     = 0;
  localparam int RANK_MED     = 4;
  localparam int RANK_MAX     = 8;
  localparam int RANK_LATENCY = 7;
  localparam int NET_N        = 9;
  localparam int NET_MAXP     = 4;

  localparam int NET_CNT [RANK_LATENCY] = '{4, 4, 4, 3, 4, 3, 3};

  localparam int NET_LO [RANK_LATENCY][NET_MAXP] = '{
    '{0, 1, 2, 4}, '{0, 2, 3, 5}, '{0, 1, 4, 7}, '{1, 3, 5, 0},
    '{0, 2, 3, 6}, '{2, 4, 6, 0}, '{1, 3, 5, 0}};

  localparam int NET_HI [RANK_LATENCY][NET_MAXP] = '{
    '{3, 7, 5, 8}, '{7, 4, 8, 6}, '{2, 3, 5, 8}, '{4, 6, 7, 0},
    '{1, 4, 5, 8}, '{3, 5, 7, 0}, '{2, 4, 6, 0}};

  // True when element idx takes part in a compare-exchange in this layer.
  function automatic bit net_paired(input int layer, input int idx);
    for (int s = 0; s < NET_MAXP; s++) begin
      if (s < NET_CNT[layer] && (NET_LO[layer][s] == idx || NET_HI[layer][s] == idx))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Ranks above the maximum fall back to the median.
  function automatic logic [3:0] rank_clamp(input logic [3:0] r);
    return (r > 4'(RANK_MAX)) ? 4'(RANK_MED) : r;
  endfunction

endpackage

// File: rtl/rank_cmp_swap.sv
// Registered compare-exchange element of the sorting network.
//  clk, rst : clock, asynchronous active-high reset
//  en_i     : global pipeline enable (hold when 0)
//  a_i, b_i : unsigned operands
//  lo_o     : registered min(a_i, b_i)
//  hi_o     : registered max(a_i, b_i)
module rank_cmp_swap #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic [DATA_WIDTH-1:0] hi_o
);

  logic [DATA_WIDTH-1:0] lo_q, hi_q, lo_d, hi_d;

  always_comb begin
    lo_d = a_i;
    hi_d = b_i;
    if (a_i > b_i) begin
      lo_d = b_i;
      hi_d = a_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (en_i) begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/rank_filter_3x3.sv
// 3x3 rank-order filter: PPC windows per beat, each sorted by a 7-stage
// pipelined network; the output pixel is s[rank] or the window centre when
// bypass is set. Rank/bypass are latched on the sof beat and travel with it.
//  clk, rst                 clock, asynchronous active-high reset
//  cfg_rank, cfg_bypass     requested rank (clamped) and centre bypass
//  in3x3_val/rdy/data       input windows, window p at [p*9*DW +: 9*DW]
//  in3x3_sof/eof/sol/eol    input markers
//  out_val/rdy/data         output pixels, pixel p at [p*DW +: DW]
//  out_sof/eof/sol/eol      output markers
//  frame_rank               rank of the frame currently at the output
module rank_filter_3x3 import rank_filter_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  cfg_rank,
  input  logic                        cfg_bypass,
  input  logic                        in3x3_val,
  output logic                        in3x3_rdy,
  input  logic [PPC*9*DATA_WIDTH-1:0] in3x3_data,
  input  logic                        in3x3_sof,
  input  logic                        in3x3_eof,
  input  logic                        in3x3_sol,
  input  logic                        in3x3_eol,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [PPC*DATA_WIDTH-1:0]   out_data,
  output logic                        out_sof,
  output logic                        out_eof,
  output logic                        out_sol,
  output logic                        out_eol,
  output logic [3:0]                  frame_rank
);

  localparam int DW  = DATA_WIDTH;
  localparam int STG = RANK_LATENCY;

  logic           en, in_fire;
  logic [STG-1:0] vld_q, sof_q, eof_q, sol_q, eol_q, byp_q;
  logic [3:0]     rank_q [STG];
  logic [3:0]     frm_rank_q, frm_rank_d, frame_rank_q, frame_rank_d;
  logic           frm_byp_q, frm_byp_d;

  // net[p][0] is the raw window; net[p][l+1] is the register output of layer l.
  logic [DW-1:0]  net [PPC][STG+1][NET_N];

  assign en        = out_rdy | ~out_val;
  assign in3x3_rdy = en & ~rst;
  assign in_fire   = in3x3_val & in3x3_rdy;

  // The sof beat itself already uses the freshly sampled configuration.
  always_comb begin
    frm_rank_d = frm_rank_q;
    frm_byp_d  = frm_byp_q;
    if (in_fire && in3x3_sof) begin
      frm_rank_d = rank_clamp(cfg_rank);
      frm_byp_d  = cfg_bypass;
    end
  end

  // frame_rank loads on the same edge that presents the out_sof beat.
  always_comb begin
    frame_rank_d = frame_rank_q;
    if (en && vld_q[STG-2] && sof_q[STG-2])
      frame_rank_d = rank_q[STG-2];
  end

  // Sideband shift register: valid, markers, bypass and rank per stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      sof_q        <= '0;
      eof_q        <= '0;
      sol_q        <= '0;
      eol_q        <= '0;
      byp_q        <= '0;
      for (int s = 0; s < STG; s++) rank_q[s] <= '0;
      frm_rank_q   <= 4'(RANK_MED);
      frm_byp_q    <= 1'b0;
      frame_rank_q <= '0;
    end else begin
      frm_rank_q   <= frm_rank_d;
      frm_byp_q    <= frm_byp_d;
      frame_rank_q <= frame_rank_d;
      if (en) begin
        vld_q     <= {vld_q[STG-2:0], in_fire};
        sof_q     <= {sof_q[STG-2:0], in_fire & in3x3_sof};
        eof_q     <= {eof_q[STG-2:0], in_fire & in3x3_eof};
        sol_q     <= {sol_q[STG-2:0], in_fire & in3x3_sol};
        eol_q     <= {eol_q[STG-2:0], in_fire & in3x3_eol};
        byp_q     <= {byp_q[STG-2:0], frm_byp_d};
        rank_q[0] <= frm_rank_d;
        for (int s = 1; s < STG; s++) rank_q[s] <= rank_q[s-1];
      end
    end
  end

  for (genvar p = 0; p < PPC; p++) begin : g_lane
    logic [DW-1:0] ctr_q [STG];

    for (genvar k = 0; k < NET_N; k++) begin : g_in
      assign net[p][0][k] = in3x3_data[p*NET_N*DW + k*DW +: DW];
    end

    for (genvar l = 0; l < STG; l++) begin : g_layer
      // Stage l boundary: compare-exchange pairs of layer l.
      for (genvar s = 0; s < NET_MAXP; s++) begin : g_cx
        if (s < NET_CNT[l]) begin : g_on
          rank_cmp_swap #(.DATA_WIDTH(DW)) u_cx (
            .clk  (clk),
            .rst  (rst),
            .en_i (en),
            .a_i  (net[p][l][NET_LO[l][s]]),
            .b_i  (net[p][l][NET_HI[l][s]]),
            .lo_o (net[p][l+1][NET_LO[l][s]]),
            .hi_o (net[p][l+1][NET_HI[l][s]])
          );
        end
      end
      // Elements idle in this layer are delayed to stay stage-aligned.
      for (genvar i = 0; i < NET_N; i++) begin : g_pass
        if (!net_paired(l, i)) begin : g_on
          logic [DW-1:0] pass_q;
          always_ff @(posedge clk or posedge rst) begin
            if (rst)     pass_q <= '0;
            else if (en) pass_q <= net[p][l][i];
          end
          assign net[p][l+1][i] = pass_q;
        end
      end
    end

    // Centre pixel for bypass rides alongside the network.
    always_ff @(posedge clk) begin
      if (en) begin
        ctr_q[0] <= net[p][0][RANK_MED];
        for (int s = 1; s < STG; s++) ctr_q[s] <= ctr_q[s-1];
      end
    end

    assign out_data[p*DW +: DW] = byp_q[STG-1] ? ctr_q[STG-1] : net[p][STG][rank_q[STG-1]];
  end

  assign out_val    = vld_q[STG-1];
  assign out_sof    = sof_q[STG-1];
  assign out_eof    = eof_q[STG-1];
  assign out_sol    = sol_q[STG-1];
  assign out_eol    = eol_q[STG-1];
  assign frame_rank = frame_rank_q;

endmodule

// File: tb/tb_rank_filter_3x3.sv
module tb_rank_filter_3x3;

  logic         clk, rst;
  logic [3:0]   cfg_rank;
  logic         cfg_bypass;
  logic         in_val, in_rdy, in_sof, in_eof, in_sol, in_eol;
  logic [287:0] in_data;
  logic         out_val, out_rdy, out_sof, out_eof, out_sol, out_eol;
  logic [31:0]  out_data;
  logic [3:0]   frame_rank;

  int n_cmp = 0;
  int n_bad = 0;

  rank_filter_3x3 #(.DATA_WIDTH(8), .PPC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_rank   (cfg_rank),
    .cfg_bypass (cfg_bypass),
    .in3x3_val  (in_val),
    .in3x3_rdy  (in_rdy),
    .in3x3_data (in_data),
    .in3x3_sof  (in_sof),
    .in3x3_eof  (in_eof),
    .in3x3_sol  (in_sol),
    .in3x3_eol  (in_eol),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .frame_rank (frame_rank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Reference ranking by insertion sort.
  function automatic logic [7:0] rk(input logic [71:0] w, input int r, input bit b);
    logic [7:0] a [9];
    logic [7:0] t;
    if (b) return w[39:32];
    for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0; j--)
        if (a[j-1] > a[j]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    return a[r];
  endfunction

  // One isolated beat: accepted on the next edge, result exactly 7 cycles later.
  task automatic beat(input string tag, input logic [287:0] d, input logic [3:0] mk,
                      input logic [31:0] exp_d, input logic [3:0] exp_fr);
    in_data = d;
    {in_sof, in_eof, in_sol, in_eol} = mk;
    in_val = 1'b1;
    chk({tag, "/in_rdy"}, 64'(in_rdy), 64'd1);
    step();
    in_val = 1'b0;
    {in_sof, in_eof, in_sol, in_eol} = 4'b0;
    repeat (5) step();
    chk({tag, "/early"}, 64'(out_val), 64'd0);
    step();
    chk({tag, "/out_val"}, 64'(out_val), 64'd1);
    chk({tag, "/data"}, 64'(out_data), 64'(exp_d));
    chk({tag, "/markers"}, 64'({out_sof, out_eof, out_sol, out_eol}), 64'(mk));
    chk({tag, "/frame_rank"}, 64'(frame_rank), 64'(exp_fr));
    step();
    chk({tag, "/after"}, 64'(out_val), 64'd0);
  endtask

  localparam int NB = 300;

  initial begin
    logic [71:0] w1, wc, l1, l2, l3;
    logic [35:0] sbq [$];
    logic [35:0] e, held;
    logic        stall_prev;
    int          sent, got, mr;
    bit          mb;

    w1 = pk(8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5);
    wc = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    l1 = pk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0);
    l2 = {9{8'h33}};
    l3 = pk(8'd0, 8'hFF, 8'd0, 8'hFF, 8'd0, 8'hFF, 8'd0, 8'hFF, 8'd0);

    rst = 1'b1; out_rdy = 1'b1; in_val = 1'b0; in_data = '0;
    {in_sof, in_eof, in_sol, in_eol} = 4'b0;
    cfg_rank = 4'd0; cfg_bypass = 1'b0;
    step(); step();
    chk("reset/out_val", 64'(out_val), 64'd0);
    chk("reset/in_rdy", 64'(in_rdy), 64'd0);
    chk("reset/out_data", 64'(out_data), 64'd0);
    chk("reset/markers", 64'({out_sof, out_eof, out_sol, out_eol}), 64'd0);
    chk("reset/frame_rank", 64'(frame_rank), 64'd0);
    rst = 1'b0;
    step();

    // Before any sof the median is used regardless of cfg_rank.
    beat("pre_sof", {4{w1}}, 4'b0011, {4{8'd5}}, 4'd0);
    cfg_rank = 4'd4;
    beat("median", {4{w1}}, 4'b1111, {4{8'd5}}, 4'd4);
    cfg_rank = 4'd0;
    beat("rank0", {4{w1}}, 4'b1010, {4{8'd1}}, 4'd0);
    cfg_rank = 4'd8;
    beat("rank0_midframe", {4{w1}}, 4'b0101, {4{8'd1}}, 4'd0);
    beat("rank8", {4{w1}}, 4'b1111, {4{8'd9}}, 4'd8);
    cfg_rank = 4'd13;
    beat("clamp", {4{w1}}, 4'b1100, {4{8'd5}}, 4'd4);
    cfg_rank = 4'd8; cfg_bypass = 1'b1;
    beat("bypass", {4{wc}}, 4'b1111, {4{8'hAB}}, 4'd8);
    cfg_bypass = 1'b0;
    beat("bypass_held", {4{w1}}, 4'b0001, {4{8'd7}}, 4'd8);

    // Distinct windows per lane.
    cfg_rank = 4'd6;
    beat("lanes_r6", {l3, l2, l1, w1}, 4'b1000, {8'hFF, 8'h33, 8'd6, 8'd7}, 4'd6);
    cfg_rank = 4'd2;
    beat("lanes_r2", {l3, l2, l1, w1}, 4'b1000, {8'h00, 8'h33, 8'd2, 8'd3}, 4'd2);
    cfg_bypass = 1'b1;
    beat("lanes_byp", {l3, l2, l1, w1}, 4'b1000, {8'h00, 8'h33, 8'd4, 8'd7}, 4'd2);
    cfg_bypass = 1'b0;

    // Reset with five beats in flight.
    cfg_rank = 4'd8;
    in_data = {4{w1}}; in_val = 1'b1; in_sof = 1'b1;
    step();
    in_sof = 1'b0;
    repeat (4) step();
    in_val = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_flight/out_val", 64'(out_val), 64'd0);
    chk("rst_flight/in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_flight/out_data", 64'(out_data), 64'd0);
    step(); step();
    chk("rst_flight/in_rdy_hold", 64'(in_rdy), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_flight/no_stale", 64'(out_val), 64'd0);
    end
    cfg_rank = 4'd0;
    beat("rst_rank_revert", {4{w1}}, 4'b0000, {4{8'd5}}, 4'd0);

    // Random valid/ready traffic against the reference.
    mr = 4; mb = 1'b0; sent = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 20000 && got < NB; cyc++) begin
      if (stall_prev)
        chk("rnd/hold", 64'({out_val, out_data, out_sof, out_eof, out_sol, out_eol}), 64'({1'b1, held}));
      out_rdy    = 1'($urandom_range(0, 1));
      in_val     = (sent < NB) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      in_sof     = ($urandom_range(0, 7) == 0);
      in_eof     = ($urandom_range(0, 7) == 0);
      in_sol     = ($urandom_range(0, 3) == 0);
      in_eol     = ($urandom_range(0, 3) == 0);
      cfg_rank   = 4'($urandom_range(0, 15));
      cfg_bypass = ($urandom_range(0, 3) == 0);
      #1;
      if (in_val && in_rdy) begin
        if (in_sof) begin
          mr = (cfg_rank > 4'd8) ? 4 : int'(cfg_rank);
          mb = cfg_bypass;
        end
        for (int p = 0; p < 4; p++) e[p*8 +: 8] = rk(in_data[p*72 +: 72], mr, mb);
        e[35:32] = {in_sof, in_eof, in_sol, in_eol};
        sbq.push_back(e);
        sent++;
      end
      if (out_val && out_rdy) begin
        if (sbq.size() == 0) begin
          chk("rnd/unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rnd/beat", 64'({out_sof, out_eof, out_sol, out_eol, out_data}), 64'(e));
        end
        got++;
      end
      stall_prev = out_val && !out_rdy;
      held = {out_data, out_sof, out_eof, out_sol, out_eol};
      @(posedge clk);
      #1;
    end
    chk("rnd/count", 64'(got), 64'(NB));
    chk("rnd/leftover", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
